// File: rtl/stdp_array_if.sv
// Bundle of spike inputs, learning controls, host write port and learned-state outputs
// exchanged between a stimulus/host side (master) and the STDP array (slave).
interface stdp_array_if #(
    parameter int NUM_PRE = 4,
    parameter int TW      = 4,
    parameter int WW      = 8
) ();
    localparam int IW = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1;

    logic [NUM_PRE-1:0]    pre_spike;
    logic                  post_spike;
    logic                  learn_en;
    logic                  wr_en;
    logic [IW-1:0]         wr_idx;
    logic [WW-1:0]         wr_data;
    logic [NUM_PRE*WW-1:0] weights;
    logic [NUM_PRE*TW-1:0] pre_time;
    logic [TW-1:0]         post_time;
    logic [NUM_PRE-1:0]    update_mask;
    logic                  update_flag;

    modport master (
        output pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data,
        input  weights, pre_time, post_time, update_mask, update_flag
    );

    modport slave (
        input  pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data,
        output weights, pre_time, post_time, update_mask, update_flag
    );
endinterface

// File: rtl/stdp_array.sv
// Pair-based STDP for NUM_PRE synapses onto one neuron: saturating spike timers,
// windowed linear LTP/LTD kernel, clamped weights and a host weight-load port.
module stdp_array #(
    parameter int NUM_PRE = 4,
    parameter int TW      = 4,
    parameter int WW      = 8,
    parameter int WIN     = 8,
    parameter int W_INIT  = 0
) (
    input logic         clk,
    input logic         rst,
    stdp_array_if.slave bus
);
    localparam int IW = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1;
    localparam int SW = ((WW > TW) ? WW : TW) + 1;
    localparam logic [TW-1:0] TMAX     = '1;
    localparam logic [TW-1:0] WIN_T    = TW'(WIN);
    localparam logic [SW-1:0] WMAX_S   = SW'({WW{1'b1}});
    localparam logic [WW-1:0] W_INIT_W = WW'(W_INIT);

    logic [TW-1:0]      preTime_q [NUM_PRE];
    logic [TW-1:0]      preTime_d [NUM_PRE];
    logic [TW-1:0]      postTime_q, postTime_d;
    logic [WW-1:0]      weight_q [NUM_PRE];
    logic [WW-1:0]      weight_d [NUM_PRE];
    logic [NUM_PRE-1:0] updMask_q, updMask_d;

    function automatic logic [TW-1:0] nextTimer(input logic spike, input logic [TW-1:0] t);
        if (spike)
            return '0;
        else if (t == TMAX)
            return t;
        else
            return t + TW'(1);
    endfunction

    // LTP and LTD are mutually exclusive because LTD requires post_spike low;
    // a host write to a channel wins over learning and hides its event.
    always_comb begin
        logic [TW-1:0] dPre;
        logic          ltp, ltd, wrHit;
        logic [SW-1:0] wExt, delta, sum;

        postTime_d = nextTimer(bus.post_spike, postTime_q);
        for (int i = 0; i < NUM_PRE; i++) begin
            dPre  = bus.pre_spike[i] ? '0 : preTime_q[i];
            ltp   = bus.learn_en && bus.post_spike && (dPre < WIN_T);
            ltd   = bus.learn_en && bus.pre_spike[i] && !bus.post_spike && (postTime_q < WIN_T);
            wrHit = bus.wr_en && (bus.wr_idx == IW'(i));
            delta = ltp ? SW'(WIN_T - dPre) : SW'(WIN_T - postTime_q);
            wExt  = SW'(weight_q[i]);
            sum   = wExt + delta;

            weight_d[i] = weight_q[i];
            if (wrHit)
                weight_d[i] = bus.wr_data;
            else if (ltp)
                weight_d[i] = (sum > WMAX_S) ? {WW{1'b1}} : sum[WW-1:0];
            else if (ltd)
                weight_d[i] = (delta > wExt) ? '0 : WW'(wExt - delta);

            preTime_d[i] = nextTimer(bus.pre_spike[i], preTime_q[i]);
            updMask_d[i] = (ltp || ltd) && !wrHit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PRE; i++) begin
                preTime_q[i] <= TMAX;
                weight_q[i]  <= W_INIT_W;
            end
            postTime_q <= TMAX;
            updMask_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_PRE; i++) begin
                preTime_q[i] <= preTime_d[i];
                weight_q[i]  <= weight_d[i];
            end
            postTime_q <= postTime_d;
            updMask_q  <= updMask_d;
        end
    end

    for (genvar g = 0; g < NUM_PRE; g++) begin : gPack
        assign bus.weights[g*WW +: WW]  = weight_q[g];
        assign bus.pre_time[g*TW +: TW] = preTime_q[g];
    end

    assign bus.post_time   = postTime_q;
    assign bus.update_mask = updMask_q;
    assign bus.update_flag = |updMask_q;
endmodule
